calc_core_cmd_issuer: RTL and testbench

- Host-side driver of the calculation core's command and data interface.
- Holds a small program buffer of core commands. Each command word is mode, opr1 address, opr2 address and return address.
- Loads operand words into the core RAM, issues commands one at a time and waits for finished_flag before advancing, then serves result readback requests.
- Sits between the top-level pairing controller and one calculation core instance.

---
 rtl/calc_core_cmd_issuer_if.sv | 39 +++
 rtl/calc_core_cmd_issuer.sv | 209 ++++++++++++++++++++
 tb/tb_calc_core_cmd_issuer.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/calc_core_cmd_issuer_if.sv
// calc_core_cmd_issuer_if
// Command/data bus between the command issuer (master) and one calculation
// core (slave).
//   I_INPUTMODE        : core input mode (idle / input / exec / ref)
//   top_cmd            : core command word {mode, opr1, opr2, ret}
//   I_WADDR1/2, I_WDATA1/2 : core RAM write ports (active in input mode)
//   I_RADDR1/2         : core RAM read addresses (used in ref mode)
//   outdata1/2         : core RAM read data
//   finished_flag      : core command complete
interface calc_core_cmd_issuer_if #(
    parameter int WORD_SIZE     = 384,
    parameter int RAM_ADDR_SIZE = 8,
    parameter int MODE_SIZE     = 4,
    parameter int CMD_SIZE      = MODE_SIZE + 3 * RAM_ADDR_SIZE
);
    logic [1:0]               I_INPUTMODE;
    logic [CMD_SIZE-1:0]      top_cmd;
    logic [RAM_ADDR_SIZE-1:0] I_WADDR1;
    logic [RAM_ADDR_SIZE-1:0] I_WADDR2;
    logic [WORD_SIZE-1:0]     I_WDATA1;
    logic [WORD_SIZE-1:0]     I_WDATA2;
    logic [RAM_ADDR_SIZE-1:0] I_RADDR1;
    logic [RAM_ADDR_SIZE-1:0] I_RADDR2;
    logic [WORD_SIZE-1:0]     outdata1;
    logic [WORD_SIZE-1:0]     outdata2;
    logic                     finished_flag;

    modport master (
        output I_INPUTMODE, top_cmd, I_WADDR1, I_WADDR2, I_WDATA1, I_WDATA2,
               I_RADDR1, I_RADDR2,
        input  outdata1, outdata2, finished_flag
    );

    modport slave (
        input  I_INPUTMODE, top_cmd, I_WADDR1, I_WADDR2, I_WDATA1, I_WDATA2,
               I_RADDR1, I_RADDR2,
        output outdata1, outdata2, finished_flag
    );
endinterface

// File: rtl/calc_core_cmd_issuer.sv
// calc_core_cmd_issuer
// Host-side driver for one calculation core: holds a program buffer of core
// commands, loads operands into core RAM, issues commands one at a time
// (waiting for finished_flag) and serves result readback requests.
// Ports:
//   clk, rst                 : clock, synchronous active-high reset
//   prog_we/prog_waddr/prog_wdata : program buffer write (IDLE only)
//   ld_valid/ld_ready, ld_addr1/2, ld_data1/2 : operand-load handshake
//   start, prog_len          : run program entries 0..prog_len-1
//   rd_req, rd_addr1/2       : readback request (IDLE only)
//   rd_valid, rd_data1/2     : registered readback result
//   core                     : master side of the core bus
//   busy, done, err          : status (err only with the watchdog)
// Optional watchdog: define CALC_ISSUER_TIMEOUT_EN.
module calc_core_cmd_issuer #(
    parameter int WORD_SIZE     = 384,
    parameter int RAM_ADDR_SIZE = 8,
    parameter int MODE_SIZE     = 4,
    parameter int CMD_SIZE      = MODE_SIZE + 3 * RAM_ADDR_SIZE,
    parameter int PROG_DEPTH    = 64,
    parameter int PC_SIZE       = 6,
    parameter logic [1:0] INM_IDLE  = 2'd0,
    parameter logic [1:0] INM_INPUT = 2'd1,
    parameter logic [1:0] INM_EXEC  = 2'd2,
    parameter logic [1:0] INM_REF   = 2'd3,
    parameter int TIMEOUT       = 4096
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     prog_we,
    input  logic [PC_SIZE-1:0]       prog_waddr,
    input  logic [CMD_SIZE-1:0]      prog_wdata,
    input  logic                     ld_valid,
    output logic                     ld_ready,
    input  logic [RAM_ADDR_SIZE-1:0] ld_addr1,
    input  logic [RAM_ADDR_SIZE-1:0] ld_addr2,
    input  logic [WORD_SIZE-1:0]     ld_data1,
    input  logic [WORD_SIZE-1:0]     ld_data2,
    input  logic                     start,
    input  logic [PC_SIZE:0]         prog_len,
    input  logic                     rd_req,
    input  logic [RAM_ADDR_SIZE-1:0] rd_addr1,
    input  logic [RAM_ADDR_SIZE-1:0] rd_addr2,
    output logic                     rd_valid,
    output logic [WORD_SIZE-1:0]     rd_data1,
    output logic [WORD_SIZE-1:0]     rd_data2,
    calc_core_cmd_issuer_if.master   core,
    output logic                     busy,
    output logic                     done,
    output logic                     err
);
    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_ISSUE, S_WAIT, S_GAP, S_READ, S_DONE
    } state_t;

    state_t               state, state_d;
    logic [PC_SIZE-1:0]   pc, pc_d;
    logic [PC_SIZE:0]     len;
    logic                 rd_phase;   // 0: address cycle, 1: capture cycle
    logic [CMD_SIZE-1:0]  prog_buf [PROG_DEPTH];

`ifdef CALC_ISSUER_TIMEOUT_EN
    logic [12:0]          wd_cnt;
    logic                 wd_expire;
    assign wd_expire = (state == S_WAIT) && !core.finished_flag &&
                       (wd_cnt == 13'(TIMEOUT - 1));
`endif

    always_comb begin
        state_d = state;
        pc_d    = pc;
        case (state)
            S_IDLE: begin
                if (ld_valid) begin
                    state_d = S_LOAD;
                end else if (start) begin
                    if (prog_len == '0) begin
                        state_d = S_DONE;
                    end else begin
                        pc_d    = '0;
                        state_d = S_ISSUE;
                    end
                end else if (rd_req) begin
                    state_d = S_READ;
                end
            end
            S_LOAD:  state_d = S_IDLE;
            S_ISSUE: state_d = S_WAIT;
            S_WAIT: begin
                if (core.finished_flag) begin
                    state_d = S_GAP;
                end
`ifdef CALC_ISSUER_TIMEOUT_EN
                else if (wd_expire) begin
                    state_d = S_DONE;
                end
`endif
            end
            S_GAP: begin
                if (({1'b0, pc} + 1'b1) < len) begin
                    pc_d    = pc + 1'b1;
                    state_d = S_ISSUE;
                end else begin
                    state_d = S_DONE;
                end
            end
            S_READ:  state_d = rd_phase ? S_IDLE : S_READ;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Program buffer is intentionally not reset.
    always_ff @(posedge clk) begin
        if (!rst && state == S_IDLE && prog_we) begin
            prog_buf[prog_waddr] <= prog_wdata;
        end
    end

    // Outputs are registered from the next-state decode so every output
    // reflects the state it belongs to in the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            state            <= S_IDLE;
            pc               <= '0;
            len              <= '0;
            rd_phase         <= 1'b0;
            ld_ready         <= 1'b0;
            busy             <= 1'b0;
            done             <= 1'b0;
            rd_valid         <= 1'b0;
            rd_data1         <= '0;
            rd_data2         <= '0;
            core.I_INPUTMODE <= INM_IDLE;
            core.top_cmd     <= '0;
            core.I_WADDR1    <= '0;
            core.I_WADDR2    <= '0;
            core.I_WDATA1    <= '0;
            core.I_WDATA2    <= '0;
            core.I_RADDR1    <= '0;
            core.I_RADDR2    <= '0;
        end else begin
            state    <= state_d;
            pc       <= pc_d;
            rd_phase <= (state == S_READ) && !rd_phase;
            ld_ready <= (state_d == S_IDLE);
            busy     <= (state_d != S_IDLE);
            done     <= (state_d == S_DONE);
            rd_valid <= (state == S_READ) && !rd_phase;

            if (state == S_IDLE && start && !ld_valid) begin
                len <= prog_len;
            end

            if (state == S_READ && !rd_phase) begin
                rd_data1 <= core.outdata1;
                rd_data2 <= core.outdata2;
            end

            case (state_d)
                S_LOAD:          core.I_INPUTMODE <= INM_INPUT;
                S_ISSUE, S_WAIT: core.I_INPUTMODE <= INM_EXEC;
                S_READ:          core.I_INPUTMODE <= INM_REF;
                default:         core.I_INPUTMODE <= INM_IDLE;
            endcase

            if (state_d == S_ISSUE) begin
                core.top_cmd <= prog_buf[pc_d];
            end else if (state_d != S_WAIT) begin
                core.top_cmd <= '0;
            end

            if (state == S_IDLE && state_d == S_LOAD) begin
                core.I_WADDR1 <= ld_addr1;
                core.I_WADDR2 <= ld_addr2;
                core.I_WDATA1 <= ld_data1;
                // Same address on both ports: write identical data on both.
                core.I_WDATA2 <= (ld_addr1 == ld_addr2) ? ld_data1 : ld_data2;
            end

            if (state == S_IDLE && state_d == S_READ) begin
                core.I_RADDR1 <= rd_addr1;
                core.I_RADDR2 <= rd_addr2;
            end
        end
    end

`ifdef CALC_ISSUER_TIMEOUT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            wd_cnt <= '0;
            err    <= 1'b0;
        end else begin
            if (state == S_ISSUE) begin
                wd_cnt <= '0;
            end else if (state == S_WAIT) begin
                wd_cnt <= wd_cnt + 1'b1;
            end
            if (wd_expire) begin
                err <= 1'b1;
            end
        end
    end
`else
    always_ff @(posedge clk) begin
        err <= 1'b0;
    end
`endif
endmodule

// File: tb/tb_calc_core_cmd_issuer.sv
module tb_calc_core_cmd_issuer;
    localparam int W  = 384;
    localparam int A  = 8;
    localparam int M  = 4;
    localparam int C  = M + 3 * A;
    localparam int PS = 6;
    localparam int TO = 4096;

    logic          clk = 1'b0;
    logic          rst;
    logic          prog_we;
    logic [PS-1:0] prog_waddr;
    logic [C-1:0]  prog_wdata;
    logic          ld_valid, ld_ready;
    logic [A-1:0]  ld_addr1, ld_addr2;
    logic [W-1:0]  ld_data1, ld_data2;
    logic          start;
    logic [PS:0]   prog_len;
    logic          rd_req;
    logic [A-1:0]  rd_addr1, rd_addr2;
    logic          rd_valid;
    logic [W-1:0]  rd_data1, rd_data2;
    logic          busy, done, err;

    always #5 clk = ~clk;

    calc_core_cmd_issuer_if #(.WORD_SIZE(W), .RAM_ADDR_SIZE(A), .MODE_SIZE(M)) core ();

    calc_core_cmd_issuer #(
        .WORD_SIZE(W), .RAM_ADDR_SIZE(A), .MODE_SIZE(M), .TIMEOUT(TO)
    ) dut (
        .clk(clk), .rst(rst),
        .prog_we(prog_we), .prog_waddr(prog_waddr), .prog_wdata(prog_wdata),
        .ld_valid(ld_valid), .ld_ready(ld_ready),
        .ld_addr1(ld_addr1), .ld_addr2(ld_addr2),
        .ld_data1(ld_data1), .ld_data2(ld_data2),
        .start(start), .prog_len(prog_len),
        .rd_req(rd_req), .rd_addr1(rd_addr1), .rd_addr2(rd_addr2),
        .rd_valid(rd_valid), .rd_data1(rd_data1), .rd_data2(rd_data2),
        .core(core),
        .busy(busy), .done(done), .err(err)
    );

    // Core model: finished_flag 10 cycles after a command is presented;
    // combinational RAM readback holding 0x55 at addr 7 and 0x66 at addr 8.
    int unsigned exec_cnt = 0;
    logic        core_en = 1'b1;
    always @(posedge clk) begin
        if (core.I_INPUTMODE == 2'd2) exec_cnt <= exec_cnt + 1;
        else                          exec_cnt <= 0;
    end
    assign core.finished_flag = core_en && (exec_cnt == 10);
    assign core.outdata1 = (core.I_RADDR1 == 8'd7) ? W'('h55) : '0;
    assign core.outdata2 = (core.I_RADDR2 == 8'd8) ? W'('h66) : '0;

    int unsigned n_chk  = 0;
    int unsigned n_pass = 0;

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [C-1:0] cmds [3];
    int unsigned  cyc;
    int unsigned  done_cnt;

    initial begin
        cmds[0] = 28'h1_01_02_03;
        cmds[1] = 28'h2_04_05_06;
        cmds[2] = 28'h3_07_08_09;
        rst = 1'b1; prog_we = 1'b0; prog_waddr = '0; prog_wdata = '0;
        ld_valid = 1'b0; ld_addr1 = '0; ld_addr2 = '0; ld_data1 = '0; ld_data2 = '0;
        start = 1'b0; prog_len = '0; rd_req = 1'b0; rd_addr1 = '0; rd_addr2 = '0;
        tick(); tick();

        // Reset values
        chk("rst_inmode", W'(core.I_INPUTMODE), W'(0));
        chk("rst_top_cmd", W'(core.top_cmd), W'(0));
        chk("rst_waddr1", W'(core.I_WADDR1), W'(0));
        chk("rst_wdata2", core.I_WDATA2, W'(0));
        chk("rst_raddr1", W'(core.I_RADDR1), W'(0));
        chk("rst_rd_data1", rd_data1, W'(0));
        chk("rst_flags", W'({busy, done, rd_valid, err, ld_ready}), W'(0));
        rst = 1'b0;
        tick();
        chk("idle_ld_ready", W'(ld_ready), W'(1));

        // Program buffer
        for (int i = 0; i < 3; i++) begin
            prog_we = 1'b1; prog_waddr = PS'(i); prog_wdata = cmds[i];
            tick();
        end
        prog_we = 1'b0;

        // Load beat, distinct addresses
        ld_valid = 1'b1; ld_addr1 = 8'd3; ld_addr2 = 8'd4; ld_data1 = W'('hA); ld_data2 = W'('hB);
        tick();
        ld_valid = 1'b0;
        chk("ld_inmode", W'(core.I_INPUTMODE), W'(1));
        chk("ld_waddr1", W'(core.I_WADDR1), W'(3));
        chk("ld_waddr2", W'(core.I_WADDR2), W'(4));
        chk("ld_wdata1", core.I_WDATA1, W'('hA));
        chk("ld_wdata2", core.I_WDATA2, W'('hB));
        chk("ld_ready_low", W'(ld_ready), W'(0));
        tick();
        chk("ld_back_idle", W'({core.I_INPUTMODE, ld_ready, busy}), W'(3'b001 << 1 | 3'b000));

        // Load beat, equal addresses: port 2 takes port-1 data
        ld_valid = 1'b1; ld_addr1 = 8'd5; ld_addr2 = 8'd5; ld_data1 = W'('h11); ld_data2 = W'('h22);
        tick();
        ld_valid = 1'b0;
        chk("ldeq_waddr", W'({core.I_WADDR1, core.I_WADDR2}), W'(16'h0505));
        chk("ldeq_wdata1", core.I_WDATA1, W'('h11));
        chk("ldeq_wdata2", core.I_WDATA2, W'('h11));
        tick();

        // Back-to-back loads: held ld_valid accepted every other cycle
        ld_valid = 1'b1; ld_addr1 = 8'd9; ld_addr2 = 8'd10;
        tick();
        chk("b2b_load1", W'(core.I_INPUTMODE), W'(1));
        tick();
        chk("b2b_idle", W'(core.I_INPUTMODE), W'(0));
        tick();
        chk("b2b_load2", W'(core.I_INPUTMODE), W'(1));
        ld_valid = 1'b0;
        tick();

        // Three-command program
        prog_len = 7'd3; start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("issue%0d_inmode", k), W'(core.I_INPUTMODE), W'(2));
            chk($sformatf("issue%0d_cmd", k), W'(core.top_cmd), W'(cmds[k]));
            cyc = 1;
            while (core.I_INPUTMODE == 2'd2 && cyc < 50) begin
                tick();
                if (core.I_INPUTMODE == 2'd2) begin
                    cyc++;
                    if (core.top_cmd !== cmds[k])
                        chk($sformatf("hold%0d_cmd", k), W'(core.top_cmd), W'(cmds[k]));
                end
            end
            chk($sformatf("exec%0d_len", k), W'(cyc), W'(11));
            chk($sformatf("gap%0d", k), W'({core.I_INPUTMODE, core.top_cmd, done, busy}), W'(1));
            tick();
        end
        chk("prog_done", W'({done, busy}), W'(2'b11));
        tick();
        chk("prog_after_done", W'({done, busy, core.I_INPUTMODE}), W'(0));
        tick();
        chk("prog_no_2nd_done", W'(done), W'(0));

        // start with prog_len = 0
        prog_len = 7'd0; start = 1'b1;
        tick();
        start = 1'b0;
        chk("len0_done", W'({done, core.I_INPUTMODE}), W'(3'b100));
        tick();
        chk("len0_after", W'({done, busy, core.I_INPUTMODE}), W'(0));

        // Readback
        rd_req = 1'b1; rd_addr1 = 8'd7; rd_addr2 = 8'd8;
        tick();
        rd_req = 1'b0;
        chk("rd_c1_inmode", W'(core.I_INPUTMODE), W'(3));
        chk("rd_c1_raddr", W'({core.I_RADDR1, core.I_RADDR2}), W'(16'h0708));
        chk("rd_c1_valid", W'(rd_valid), W'(0));
        tick();
        chk("rd_valid", W'(rd_valid), W'(1));
        chk("rd_data1", rd_data1, W'('h55));
        chk("rd_data2", rd_data2, W'('h66));
        tick();
        chk("rd_after", W'({rd_valid, busy}), W'(0));

        // Reset during WAIT of the first command
        prog_len = 7'd2; start = 1'b1;
        tick();
        start = 1'b0;
        tick(); tick(); tick();
        chk("midrst_wait", W'(core.I_INPUTMODE), W'(2));
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("midrst_inmode", W'(core.I_INPUTMODE), W'(0));
        chk("midrst_cmd", W'(core.top_cmd), W'(0));
        chk("midrst_flags", W'({busy, done}), W'(0));
        done_cnt = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (done === 1'b1 || core.I_INPUTMODE !== 2'd0) done_cnt++;
        end
        chk("midrst_quiet", W'(done_cnt), W'(0));

`ifdef CALC_ISSUER_TIMEOUT_EN
        // Watchdog: core never finishes
        core_en = 1'b0;
        prog_len = 7'd2; start = 1'b1;
        tick();
        start = 1'b0;
        cyc = 0;
        while (done !== 1'b1 && cyc < TO + 100) begin
            tick();
            cyc++;
        end
        chk("wd_done", W'(done), W'(1));
        chk("wd_err", W'(err), W'(1));
        chk("wd_inmode", W'(core.I_INPUTMODE), W'(0));
        chk("wd_time", W'(cyc >= TO && cyc <= TO + 2), W'(1));
        tick();
        chk("wd_err_sticky", W'({err, busy}), W'(2'b10));
        core_en = 1'b1;
`else
        chk("err_tied", W'(err), W'(0));
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
